// File: rtl/switch_led_ctrl.sv
// switch_led_ctrl: per-channel synchroniser, debouncer and rise detector for
// front-panel switches, driving LEDs in follow / toggle / blink / invert mode.
module switch_led_ctrl #(
    parameter int N_CH            = 6,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_HALF      = 12500000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] Switch,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] LED,
    output logic [N_CH-1:0] sw_level,
    output logic [N_CH-1:0] sw_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
    localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

    typedef enum logic [1:0] {
        MODE_FOLLOW = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_INVERT = 2'b11
    } led_mode_e;

    logic [N_CH-1:0]            sync1_r;
    logic [N_CH-1:0]            sync2_r;
    logic [N_CH-1:0][CNT_W-1:0] cnt_r;
    logic [N_CH-1:0][CNT_W-1:0] cnt_nxt_s;
    logic [N_CH-1:0]            level_r;
    logic [N_CH-1:0]            level_nxt_s;
    logic [N_CH-1:0]            level_d_r;
    logic [N_CH-1:0]            rise_r;
    logic [N_CH-1:0]            rise_s;
    logic [N_CH-1:0]            tog_r;
    logic [N_CH-1:0]            led_r;
    logic [N_CH-1:0]            led_nxt_s;
    logic [BLK_W-1:0]           blk_cnt_r;
    logic [BLK_W-1:0]           blk_cnt_nxt_s;
    logic                       phase_r;
    logic                       phase_nxt_s;

    // Two-stage synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {N_CH{1'b0}};
            sync2_r <= {N_CH{1'b0}};
        end else begin
            sync1_r <= Switch;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a new level must persist for DEBOUNCE_CYCLES consecutive clocks.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        for (int i = 0; i < N_CH; i++) begin
            if (sync2_r[i] == level_r[i]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                cnt_nxt_s[i]   = {CNT_W{1'b0}};
                level_nxt_s[i] = sync2_r[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    assign rise_s = level_r & ~level_d_r;

    // Debounce counters, accepted level, rise pulse and toggle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {(N_CH*CNT_W){1'b0}};
            level_r   <= {N_CH{1'b0}};
            level_d_r <= {N_CH{1'b0}};
            rise_r    <= {N_CH{1'b0}};
            tog_r     <= {N_CH{1'b0}};
        end else begin
            cnt_r     <= cnt_nxt_s;
            level_r   <= level_nxt_s;
            level_d_r <= level_r;
            rise_r    <= rise_s;
            tog_r     <= tog_r ^ rise_s;
        end
    end

    // Shared free-running blink prescaler; phase flips on every wrap.
    always_comb begin
        blk_cnt_nxt_s = blk_cnt_r;
        phase_nxt_s   = phase_r;
        if (blk_cnt_r == BLK_LAST) begin
            blk_cnt_nxt_s = {BLK_W{1'b0}};
            phase_nxt_s   = ~phase_r;
        end else begin
            blk_cnt_nxt_s = blk_cnt_r + BLK_ONE;
        end
    end

    // Blink prescaler state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_r <= {BLK_W{1'b0}};
            phase_r   <= 1'b0;
        end else begin
            blk_cnt_r <= blk_cnt_nxt_s;
            phase_r   <= phase_nxt_s;
        end
    end

    // LED source selection; mode is quasi-static and used unsynchronised.
    always_comb begin
        led_nxt_s = {N_CH{1'b0}};
        case (mode)
            MODE_FOLLOW: led_nxt_s = level_r;
            MODE_TOGGLE: led_nxt_s = tog_r;
            MODE_BLINK:  led_nxt_s = level_r & {N_CH{phase_r}};
            MODE_INVERT: led_nxt_s = ~level_r;
            default:     led_nxt_s = {N_CH{1'b0}};
        endcase
    end

    // Registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= {N_CH{1'b0}};
        end else begin
            led_r <= led_nxt_s;
        end
    end

    assign LED      = led_r;
    assign sw_level = level_r;
    assign sw_rise  = rise_r;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Bench for switch_led_ctrl: directed scenarios plus random switch activity,
// compared every cycle against a behavioural model of the panel.
module tb_switch_led_ctrl;

    localparam int N  = 6;
    localparam int D  = 4;
    localparam int BH = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] Switch;
    logic [1:0]   mode;
    logic [N-1:0] LED;
    logic [N-1:0] sw_level;
    logic [N-1:0] sw_rise;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    logic [N-1:0] m_s1, m_s2, m_level, m_level_d, m_rise, m_tog, m_led;
    logic [N-1:0] hist [D];
    int           m_edges;

    switch_led_ctrl #(.N_CH(N), .DEBOUNCE_CYCLES(D), .BLINK_HALF(BH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Switch   (Switch),
        .mode     (mode),
        .LED      (LED),
        .sw_level (sw_level),
        .sw_rise  (sw_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_level_d = '0;
        m_rise = '0; m_tog = '0; m_led = '0; m_edges = 0;
        for (int k = 0; k < D; k++) hist[k] = '0;
    endtask

    // One clock edge: the level flips once the synchronised input has
    // disagreed with it on each of the last D edges.
    task automatic model_edge();
        logic         phase;
        logic [N-1:0] nlevel, nrise, nled;
        bit           all_diff;
        phase = ((m_edges / BH) % 2) != 0;
        for (int k = D - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = m_s2;
        for (int c = 0; c < N; c++) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++)
                if (hist[k][c] == m_level[c]) all_diff = 1'b0;
            nlevel[c] = all_diff ? ~m_level[c] : m_level[c];
        end
        nrise = m_level & ~m_level_d;
        case (mode)
            2'b00:   nled = m_level;
            2'b01:   nled = m_tog;
            2'b10:   nled = phase ? m_level : '0;
            default: nled = ~m_level;
        endcase
        m_tog     = m_tog ^ nrise;
        m_rise    = nrise;
        m_level_d = m_level;
        m_level   = nlevel;
        m_led     = nled;
        m_s2      = m_s1;
        m_s1      = Switch;
        m_edges   = m_edges + 1;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        @(negedge clk);
        check("led", LED, m_led);
        check("level", sw_level, m_level);
        check("rise", sw_rise, m_rise);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_led"}, LED, 6'h00);
        check({tag, "_level"}, sw_level, 6'h00);
        check({tag, "_rise"}, sw_rise, 6'h00);
    endtask

    initial begin
        int hold;
        rst_n  = 1'b0;
        Switch = 6'h3F;
        mode   = 2'b00;
        model_reset();

        // Reset values, then release with all switches held high
        steps(3);
        check("rst_led", LED, 6'h00);
        check("rst_level", sw_level, 6'h00);
        rst_n = 1'b1;
        steps(5);
        check("rel_level_early", sw_level, 6'h00);
        step();
        check("rel_level", sw_level, 6'h3F);
        check("rel_rise_early", sw_rise, 6'h00);
        step();
        check("rel_rise", sw_rise, 6'h3F);
        check("rel_led", LED, 6'h3F);
        step();
        check("rel_rise_end", sw_rise, 6'h00);

        // Glitch rejection on channel 2, then a real press
        Switch = 6'h00;
        steps(10);
        Switch = 6'h04;
        steps(3);
        Switch = 6'h00;
        steps(8);
        check("glitch_level", sw_level, 6'h00);
        check("glitch_led", LED, 6'h00);
        Switch = 6'h04;
        steps(5);
        check("press_early", sw_level, 6'h00);
        step();
        check("press_level", sw_level, 6'h04);
        steps(2);
        Switch = 6'h00;
        steps(10);

        // Toggle mode: two presses on channel 1, mode excursion in between
        mode = 2'b01;
        step();
        check("tog_init", LED, 6'h3B);
        Switch = 6'h02;
        steps(10);
        Switch = 6'h00;
        steps(10);
        check("tog_first", LED, 6'h39);
        Switch = 6'h02;
        steps(10);
        Switch = 6'h00;
        steps(10);
        check("tog_second", LED, 6'h3B);
        mode = 2'b00;
        steps(3);
        check("tog_follow", LED, 6'h00);
        mode = 2'b01;
        step();
        check("tog_kept", LED, 6'h3B);

        // Blink with levels 6'h05
        mode   = 2'b10;
        Switch = 6'h05;
        steps(8);
        for (int k = 0; k < 12; k++) begin
            step();
            check("blink_mask", LED & 6'h3A, 6'h00);
        end

        // Invert mode with a simultaneous multi-channel press
        mode   = 2'b11;
        Switch = 6'h00;
        steps(10);
        check("inv_idle", LED, 6'h3F);
        Switch = 6'h2A;
        steps(6);
        check("inv_level", sw_level, 6'h2A);
        step();
        check("inv_led", LED, 6'h15);
        check("inv_rise", sw_rise, 6'h2A);
        step();
        check("inv_rise_end", sw_rise, 6'h00);

        // Asynchronous reset at count 2 of a pending transition
        Switch = 6'h3F;
        steps(4);
        async_reset_check("arst");
        steps(2);
        rst_n = 1'b1;
        mode  = 2'b00;
        steps(5);
        check("arst_early", sw_level, 6'h00);
        step();
        check("arst_level", sw_level, 6'h3F);

        // Random switch activity with occasional mode changes
        for (int n = 0; n < 60; n++) begin
            Switch = N'($urandom);
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom);
            hold = $urandom_range(1, 8);
            steps(hold);
            if (n == 30) begin
                async_reset_check("rnd_rst");
                step();
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
